// File: rtl/serial_out_seq_if.sv
// rtl/serial_out_seq_if.sv - descriptor push channel between host and serial_out_seq
interface serial_out_seq_if #(
  parameter int DATA_BIT = 32
);
  logic                desc_valid_i;
  logic                desc_ready_o;
  logic [DATA_BIT-1:0] desc_pattern_i;
  logic [DATA_BIT-1:0] desc_freq_i;
  logic [7:0]          desc_slow_i;
  logic [7:0]          desc_fast_i;
  logic [7:0]          desc_passes_i;

  modport master (
    output desc_valid_i, desc_pattern_i, desc_freq_i, desc_slow_i, desc_fast_i, desc_passes_i,
    input  desc_ready_o
  );

  modport slave (
    input  desc_valid_i, desc_pattern_i, desc_freq_i, desc_slow_i, desc_fast_i, desc_passes_i,
    output desc_ready_o
  );
endinterface

// File: rtl/serial_out_seq.sv
// rtl/serial_out_seq.sv - descriptor FIFO sequencer driving one serial_out in one-shot mode
// Optional abort path (abort_i, stop_o pulse) enabled by defining SEQ_ABORT_EN.
module serial_out_seq #(
  parameter int DATA_BIT = 32,
  parameter int QDEPTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  serial_out_seq_if.slave          desc,
  output logic [DATA_BIT-1:0]      out_pattern_o,
  output logic [DATA_BIT-1:0]      freq_pattern_o,
  output logic [7:0]               slow_period_o,
  output logic [7:0]               fast_period_o,
  output logic                     mode_o,
  output logic                     start_o,
  output logic                     stop_o,
`ifdef SEQ_ABORT_EN
  input  logic                     abort_i,
`endif
  input  logic                     done_tick_i,
  output logic                     busy_o,
  output logic                     desc_done_o,
  output logic [$clog2(QDEPTH):0]  level_o
);
  localparam int          AW   = $clog2(QDEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t              state, state_nx;
  logic [DATA_BIT-1:0] pat_mem  [QDEPTH];
  logic [DATA_BIT-1:0] freq_mem [QDEPTH];
  logic [7:0]          slow_mem [QDEPTH];
  logic [7:0]          fast_mem [QDEPTH];
  logic [7:0]          pass_mem [QDEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [7:0]          pass_left;
  logic [AW:0]         level_nx;
  logic                ready_q;
  logic                abort, push, pop, dec, done_nx;

`ifdef SEQ_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign desc.desc_ready_o = ready_q;
  assign mode_o            = 1'b0;
  // ready_q reflects the occupancy before this edge, so a full FIFO refuses a push even while popping
  assign push     = desc.desc_valid_i & ready_q & ~abort;
  assign level_nx = level_o + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    dec      = 1'b0;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (level_o != '0) begin
          pop      = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: begin
        dec      = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (done_tick_i) begin
          if (pass_left != 8'd0) begin
            state_nx = S_START;
          end else begin
            done_nx = 1'b1;
            if (level_o != '0) begin
              pop      = 1'b1;
              state_nx = S_START;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) begin
      state_nx = S_IDLE;
      pop      = 1'b0;
      dec      = 1'b0;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pat_mem[wr_ptr]  <= desc.desc_pattern_i;
      freq_mem[wr_ptr] <= desc.desc_freq_i;
      slow_mem[wr_ptr] <= desc.desc_slow_i;
      fast_mem[wr_ptr] <= desc.desc_fast_i;
      pass_mem[wr_ptr] <= desc.desc_passes_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_o        <= '0;
      ready_q        <= 1'b1;
      out_pattern_o  <= '0;
      freq_pattern_o <= '0;
      slow_period_o  <= '0;
      fast_period_o  <= '0;
      pass_left      <= '0;
      start_o        <= 1'b0;
      stop_o         <= 1'b0;
      busy_o         <= 1'b0;
      desc_done_o    <= 1'b0;
    end else begin
      state       <= state_nx;
      start_o     <= (state_nx == S_START);
      busy_o      <= (state_nx != S_IDLE);
      desc_done_o <= done_nx;
      stop_o      <= abort;
      if (abort) begin
        rd_ptr  <= wr_ptr;
        level_o <= '0;
        ready_q <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        level_o <= level_nx;
        ready_q <= (level_nx != FULL);
      end
      // holding registers only move on a pop, so the slave sees stable inputs for a whole pass
      if (pop) begin
        out_pattern_o  <= pat_mem[rd_ptr];
        freq_pattern_o <= freq_mem[rd_ptr];
        slow_period_o  <= slow_mem[rd_ptr];
        fast_period_o  <= fast_mem[rd_ptr];
        pass_left      <= (pass_mem[rd_ptr] == 8'd0) ? 8'd1 : pass_mem[rd_ptr];
      end else if (dec) begin
        pass_left <= pass_left - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_out_seq.sv
// tb/tb_serial_out_seq.sv - randomized bench for serial_out_seq with queue-based reference model
module tb_serial_out_seq;
  localparam int DB = 32;
  localparam int QD = 4;

  typedef struct packed {
    logic [31:0] pat;
    logic [31:0] freq;
    logic [7:0]  slow;
    logic [7:0]  fast;
    logic [7:0]  passes;
  } desc_t;

  logic clk = 1'b0, rst = 1'b1, done_tick = 1'b0, abort = 1'b0;
  always #5 clk = ~clk;

  serial_out_seq_if #(.DATA_BIT(DB)) dif();
  logic [DB-1:0]          out_pattern, freq_pattern;
  logic [7:0]             slow_period, fast_period;
  logic                   mode, start, stop, busy, desc_done;
  logic [$clog2(QD):0]    level;

  serial_out_seq #(.DATA_BIT(DB), .QDEPTH(QD)) dut (
    .clk_i(clk), .rst_i(rst), .desc(dif),
    .out_pattern_o(out_pattern), .freq_pattern_o(freq_pattern),
    .slow_period_o(slow_period), .fast_period_o(fast_period),
    .mode_o(mode), .start_o(start), .stop_o(stop),
`ifdef SEQ_ABORT_EN
    .abort_i(abort),
`endif
    .done_tick_i(done_tick), .busy_o(busy), .desc_done_o(desc_done), .level_o(level)
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: queue of waiting descriptors, the active one, and starts still owed
  desc_t mq[$];
  desc_t cur;
  int    m_left;
  bit    m_run, m_started, exp_start, exp_ddone, exp_stop;

  always @(posedge clk) begin : model_p
    int    sz;
    bit    take, do_pop;
    desc_t nd;
    exp_start = 0; exp_ddone = 0; exp_stop = 0;
    if (rst) begin
      mq.delete(); cur = '0; m_run = 0; m_started = 0; m_left = 0;
    end else begin
      sz     = mq.size();
      take   = dif.desc_valid_i && (sz < QD);
      do_pop = 0;
`ifdef SEQ_ABORT_EN
      if (abort) begin
        mq.delete(); m_run = 0; m_started = 0; exp_stop = 1; take = 0;
      end else
`endif
      begin
        if (!m_run) do_pop = (sz > 0);
        else if (m_started) m_started = 0;
        else if (done_tick) begin
          if (m_left > 0) begin
            m_left--; exp_start = 1; m_started = 1;
          end else begin
            exp_ddone = 1;
            if (sz > 0) do_pop = 1; else m_run = 0;
          end
        end
        if (do_pop) begin
          cur       = mq.pop_front();
          m_left    = ((cur.passes == 0) ? 1 : int'(cur.passes)) - 1;
          m_run     = 1; m_started = 1; exp_start = 1;
        end
      end
      if (take) begin
        nd = {dif.desc_pattern_i, dif.desc_freq_i, dif.desc_slow_i, dif.desc_fast_i, dif.desc_passes_i};
        mq.push_back(nd);
      end
    end
  end

  int n_start = 0, n_ddone = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("start", start, exp_start);
      chk("desc_done", desc_done, exp_ddone);
      chk("stop", stop, exp_stop);
      chk("busy", busy, m_run);
      chk("level", level, mq.size());
      chk("ready", dif.desc_ready_o, mq.size() < QD);
      chk("mode", mode, 0);
      chk("out_pattern", out_pattern, cur.pat);
      chk("freq_pattern", freq_pattern, cur.freq);
      chk("slow", slow_period, cur.slow);
      chk("fast", fast_period, cur.fast);
    end
    n_start += int'(start);
    n_ddone += int'(desc_done);
  end

  // slave stand-in: done_tick after the sum of per-bit periods, optional spurious ticks while idle
  bit active = 0, sp_en = 0;
  int cnt = 0, last_total = 0;

  function automatic int total(input logic [31:0] f, input logic [7:0] s, input logic [7:0] fa);
    int t = 0;
    for (int i = 0; i < 32; i++)
      t += f[i] ? ((fa == 0) ? 1 : int'(fa)) : ((s == 0) ? 1 : int'(s));
    return t;
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst || stop) begin
        active = 0; done_tick = 0;
      end else begin
        if (done_tick) begin done_tick = 0; active = 0; end
        if (start) begin
          chk("start_while_slave_busy", active, 0);
          active = 1;
          cnt = total(freq_pattern, slow_period, fast_period);
          last_total = cnt;
        end else if (active) begin
          cnt--;
          if (cnt == 0) done_tick = 1;
        end else if (sp_en && $urandom_range(15) == 0) begin
          done_tick = 1;
        end
      end
    end
  end

  task automatic push(input desc_t d, output int waited);
    bit acc;
    dif.desc_valid_i   = 1;
    dif.desc_pattern_i = d.pat;  dif.desc_freq_i = d.freq;
    dif.desc_slow_i    = d.slow; dif.desc_fast_i = d.fast;
    dif.desc_passes_i  = d.passes;
    waited = 0;
    forever begin
      acc = dif.desc_ready_o;
      @(posedge clk); #1;
      if (acc) break;
      waited++;
      if (waited > 5000) begin
        n_chk++; n_fail++;
        $display("FAIL push_timeout actual=held required=accepted");
        break;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 20000; k++) begin
      if (!busy && level == 0 && !active && !done_tick) break;
      @(posedge clk); #1;
    end
    if (k == 20000) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout actual=busy required=idle", nm);
    end
    @(posedge clk); #1;
  endtask

  initial begin : main
    int w, s0, d0;
    desc_t d;
    dif.desc_valid_i = 0; dif.desc_pattern_i = '0; dif.desc_freq_i = '0;
    dif.desc_slow_i = '0; dif.desc_fast_i = '0; dif.desc_passes_i = '0;
    @(posedge clk); chk_en = 1; #1;
    @(posedge clk); #1; rst = 0;
    chk("init_level", level, 0);
    chk("init_ready", dif.desc_ready_o, 1);

    // T1: reset with three descriptors queued behind an active one
    for (int i = 0; i < 4; i++) begin
      d = '{pat: 32'h1234_0000 + i, freq: 32'h0, slow: 8'd3, fast: 8'd1, passes: 8'd3};
      push(d, w);
    end
    dif.desc_valid_i = 0;
    chk("t1_pre_level", level, 3);
    rst = 1; @(posedge clk); #1; rst = 0;
    chk("t1_level", level, 0);
    chk("t1_busy", busy, 0);
    chk("t1_start", start, 0);
    chk("t1_ready", dif.desc_ready_o, 1);
    @(posedge clk); #1;

    // T2: single descriptor, start appears on the second edge after valid
    s0 = n_start; d0 = n_ddone;
    dif.desc_valid_i = 1; dif.desc_pattern_i = 32'hA5A5_0F0F; dif.desc_freq_i = 32'h0;
    dif.desc_slow_i = 8'd4; dif.desc_fast_i = 8'd2; dif.desc_passes_i = 8'd1;
    @(posedge clk); #1; dif.desc_valid_i = 0;
    chk("t2_no_start_yet", start, 0);
    @(posedge clk); #1;
    chk("t2_start", start, 1);
    chk("t2_pattern", out_pattern, 32'hA5A5_0F0F);
    chk("t2_slow", slow_period, 8'd4);
    wait_idle("t2");
    chk("t2_bit_clocks", last_total, 128);
    chk("t2_starts", n_start - s0, 1);
    chk("t2_desc_done", n_ddone - d0, 1);

    // T3 / T4: multiple passes, and passes=0 acting as one
    s0 = n_start; d0 = n_ddone;
    d = '{pat: 32'hDEAD_BEEF, freq: 32'hF0F0_00FF, slow: 8'd1, fast: 8'd2, passes: 8'd3};
    push(d, w); dif.desc_valid_i = 0;
    wait_idle("t3");
    chk("t3_starts", n_start - s0, 3);
    chk("t3_desc_done", n_ddone - d0, 1);
    s0 = n_start; d0 = n_ddone;
    d = '{pat: 32'h0000_0001, freq: 32'h0, slow: 8'd1, fast: 8'd1, passes: 8'd0};
    push(d, w); dif.desc_valid_i = 0;
    wait_idle("t4");
    chk("t4_starts", n_start - s0, 1);
    chk("t4_desc_done", n_ddone - d0, 1);

    // T5: fill the FIFO behind an active descriptor; the next push is held
    s0 = n_start; d0 = n_ddone;
    for (int i = 0; i < QD + 1; i++) begin
      d = '{pat: 32'hC0DE_0000 + i, freq: 32'h0, slow: 8'd1, fast: 8'd1, passes: 8'd1};
      push(d, w);
    end
    chk("t5_level_full", level, QD);
    chk("t5_ready_low", dif.desc_ready_o, 0);
    d = '{pat: 32'hC0DE_00FF, freq: 32'hFFFF_FFFF, slow: 8'd1, fast: 8'd2, passes: 8'd1};
    push(d, w); dif.desc_valid_i = 0;
    chk("t5_held", w > 0, 1);
    wait_idle("t5");
    chk("t5_starts", n_start - s0, QD + 2);
    chk("t5_desc_done", n_ddone - d0, QD + 2);

`ifdef SEQ_ABORT_EN
    // T6: abort mid-pass with two descriptors queued
    for (int i = 0; i < 3; i++) begin
      d = '{pat: 32'hAB00_0000 + i, freq: 32'h0, slow: 8'd3, fast: 8'd1, passes: 8'd2};
      push(d, w);
    end
    dif.desc_valid_i = 0;
    repeat (10) begin @(posedge clk); #1; end
    abort = 1; @(posedge clk); #1; abort = 0;
    chk("t6_stop", stop, 1);
    chk("t6_level", level, 0);
    chk("t6_busy", busy, 0);
    s0 = n_start; d0 = n_ddone;
    repeat (300) begin @(posedge clk); #1; end
    chk("t6_no_start", n_start - s0, 0);
    chk("t6_no_desc_done", n_ddone - d0, 0);
`endif

    // randomized traffic with spurious done ticks while the slave is idle
    sp_en = 1;
    for (int i = 0; i < 40; i++) begin
      d.pat    = $urandom;
      d.freq   = $urandom;
      d.slow   = 8'($urandom_range(1, 3));
      d.fast   = 8'($urandom_range(1, 3));
      d.passes = 8'($urandom_range(0, 3));
      push(d, w);
      if ($urandom_range(3) != 0) begin
        dif.desc_valid_i = 0;
        repeat ($urandom_range(0, 80)) begin @(posedge clk); #1; end
      end
    end
    dif.desc_valid_i = 0;
    wait_idle("rand");
    sp_en = 0;
    repeat (4) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
